crc16_frame_checker: RTL and testbench
======================================

CRC16_FRAME_CHECKER -- requirements
Module: crc16_frame_checker

Interface
REQ-001 Parameter POLY, default 16'h1021, CRC-16 generator polynomial; x^16 term implicit.
REQ-002 Parameter INIT, default 16'h0000, running-CRC value at the start of each frame.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  16  frame word; the last word of a frame is the received CRC.
REQ-006 in_valid  input  1  in_data/in_last valid.
REQ-007 in_last  input  1  marks the received-CRC word (final word of the frame).
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 out_data  output  16  payload word forwarded downstream; the CRC word is stripped.
REQ-010 out_valid  output  1  out_data/out_last valid.
REQ-011 out_last  output  1  marks the last payload word of the frame.
REQ-012 out_ready  input  1  downstream accepts the word this cycle.
REQ-013 crc_done  output  1  one-cycle pulse when a frame's CRC word is accepted.
REQ-014 crc_ok  output  1  result of the frame just completed; valid with crc_done, held until the next crc_done.
REQ-015 calc_crc  output  16  running CRC; after crc_done, holds the final computed CRC of the completed frame.
REQ-016 frame_cnt  output  16  count of completed frames, saturating at 16'hFFFF.
REQ-017 err_cnt  output  16  count of failed or runt frames, saturating at 16'hFFFF.

Function
REQ-018 A transfer occurs when in_valid and in_ready are both high; a downstream transfer occurs when out_valid and out_ready are both high.
REQ-019 CRC update per payload word: crc_next equals 16 bit-serial steps over the word, MSB first, non-reflected, no final XOR; equivalently crc_next = ((crc ^ word) * x^16) mod POLY.
REQ-020 The CRC word (in_last=1) is compared, not folded in: crc_ok = (in_data == running CRC before that word).
REQ-021 State machine:
- IDLE: no word held.
- BODY: one payload word held in the hold register H.
- DRAIN: H moved to the output register as last.
REQ-022 The hold register delays each payload word by one accepted word, so out_last can be set on the word preceding the CRC word.
REQ-023 Accepting a payload word while H is full moves H to the output register with out_last=0, loads the new word into H, and updates the CRC.
REQ-024 Accepting the CRC word while H is full moves H to the output register with out_last=1, pulses crc_done, updates crc_ok and the counters, reloads the running CRC to INIT, and returns to IDLE.
REQ-025 Runt frame (CRC word accepted in IDLE, no payload): emit no output, crc_done=1, crc_ok=0, err_cnt increments, frame_cnt increments.
REQ-026 in_ready = !(H full and output register full and out_ready=0); in_ready has no combinational dependency on in_valid.
REQ-027 The output register holds out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-028 Back-to-back frames: the first word of the next frame may be accepted in the cycle after the CRC word, with zero bubbles; the new frame's CRC starts from INIT.
REQ-029 Counters saturate at 16'hFFFF and do not wrap.
REQ-030 Throughput: one word per cycle when out_ready=1 continuously; latency from payload acceptance to out_valid is 1 cycle after the next word is accepted.

Reset
REQ-031 On reset low, immediately:
- out_valid=0, out_last=0, out_data=0
- crc_done=0, crc_ok=0
- calc_crc=INIT
- frame_cnt=0, err_cnt=0
- H empty, state IDLE
- in_ready=1 after release.
REQ-032 Reset mid-frame discards H, the output register and the partial CRC; no crc_done is produced for the aborted frame.

Verification
REQ-033 Frame {0x0001, CRC 0x1021} with out_ready=1 -> out_data=0x0001 with out_last=1; crc_done=1; crc_ok=1; frame_cnt=1; err_cnt=0.
REQ-034 Frame {0x0000, 0x0001, CRC 0x1021} -> outputs 0x0000 (last=0) then 0x0001 (last=1); crc_ok=1.
REQ-035 Frame {0x0001, CRC 0x1020} -> payload forwarded; crc_ok=0; err_cnt=1; calc_crc=0x1021.
REQ-036 CRC word alone (in_last=1, 0x0000) in IDLE -> no out_valid; crc_done=1; crc_ok=0; err_cnt=1.
REQ-037 out_ready held 0 during a 4-word payload -> in_ready drops after 2 accepted words; out_data stable; no loss or duplication after out_ready=1.
REQ-038 reset asserted after 2 payload words, then frame {0x0001, CRC 0x1021} -> no stale output; crc_ok=1; frame_cnt=1.

Source files
------------

// File: rtl/crc16_frame_checker_if.sv
// Word-stream bundle around the CRC16 frame checker: an upstream frame channel
// and a downstream payload channel, each with valid/ready flow control.
interface crc16_frame_checker_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/crc16_frame_checker.sv
// CRC-16 frame checker: forwards payload words, strips and compares the trailing
// CRC word, and reports per-frame status plus saturating frame/error counters.
module crc16_frame_checker #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic                   clk,
  input  logic                   reset,
  crc16_frame_checker_if.slave   bus,
  output logic                   crc_done,
  output logic                   crc_ok,
  output logic [15:0]            calc_crc,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            err_cnt
);

  typedef enum logic [1:0] {IDLE, BODY, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [15:0] hold_reg;
  logic [15:0] obuf_data_reg;
  logic        obuf_last_reg;
  logic        obuf_valid_reg;
  logic [15:0] crc_reg;
  logic [15:0] calc_reg;
  logic        done_reg;
  logic        ok_reg;
  logic [15:0] frame_cnt_reg;
  logic [15:0] err_cnt_reg;

  logic        hold_full;
  logic        in_ready;
  logic        in_fire;
  logic        out_fire;
  logic        load_hold;
  logic        push_out;
  logic        push_last;
  logic        frame_end;
  logic        frame_good;
  logic [15:0] crc_next;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [15:0] word);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ word[i]) c = {c[14:0], 1'b0} ^ POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign hold_full  = (state_reg == BODY);
  // Stall only when both stages are occupied and the output cannot drain this cycle.
  assign in_ready   = !(hold_full && obuf_valid_reg && !bus.out_ready);
  assign in_fire    = bus.in_valid && in_ready;
  assign out_fire   = obuf_valid_reg && bus.out_ready;
  assign crc_next   = crc_step(crc_reg, bus.in_data);
  assign frame_good = hold_full && (bus.in_data == crc_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_hold  = 1'b0;
    push_out   = 1'b0;
    push_last  = 1'b0;
    frame_end  = 1'b0;
    if (in_fire) begin
      if (!bus.in_last) begin
        load_hold  = 1'b1;
        push_out   = hold_full;
        state_next = BODY;
      end else begin
        frame_end  = 1'b1;
        push_out   = hold_full;
        push_last  = hold_full;
        // A runt arriving while the previous last word is still queued keeps DRAIN.
        state_next = (hold_full || (state_reg == DRAIN && !out_fire)) ? DRAIN : IDLE;
      end
    end else if (state_reg == DRAIN && out_fire) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_reg       <= 16'h0000;
      obuf_data_reg  <= 16'h0000;
      obuf_last_reg  <= 1'b0;
      obuf_valid_reg <= 1'b0;
      crc_reg        <= INIT;
      calc_reg       <= INIT;
      done_reg       <= 1'b0;
      ok_reg         <= 1'b0;
      frame_cnt_reg  <= 16'h0000;
      err_cnt_reg    <= 16'h0000;
    end else begin
      done_reg <= frame_end;
      if (push_out) begin
        obuf_data_reg  <= hold_reg;
        obuf_last_reg  <= push_last;
        obuf_valid_reg <= 1'b1;
      end else if (out_fire) begin
        obuf_valid_reg <= 1'b0;
      end
      if (load_hold) begin
        hold_reg <= bus.in_data;
        crc_reg  <= crc_next;
        calc_reg <= crc_next;
      end
      if (frame_end) begin
        // calc_crc keeps the finished frame's CRC while the running CRC restarts.
        crc_reg       <= INIT;
        calc_reg      <= crc_reg;
        ok_reg        <= frame_good;
        frame_cnt_reg <= sat_inc(frame_cnt_reg);
        if (!frame_good) err_cnt_reg <= sat_inc(err_cnt_reg);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = obuf_data_reg;
  assign bus.out_last  = obuf_last_reg;
  assign bus.out_valid = obuf_valid_reg;
  assign crc_done      = done_reg;
  assign crc_ok        = ok_reg;
  assign calc_crc      = calc_reg;
  assign frame_cnt     = frame_cnt_reg;
  assign err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Bench for crc16_frame_checker: fixed frame table, stall/reset sequences and
// random traffic scored against a polynomial-division reference model.
module tb_crc16_frame_checker;
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] INIT = 16'h0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  crc16_frame_checker_if bus();
  logic        crc_done, crc_ok;
  logic [15:0] calc_crc, frame_cnt, err_cnt;

  crc16_frame_checker #(.POLY(POLY), .INIT(INIT)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .crc_done(crc_done), .crc_ok(crc_ok), .calc_crc(calc_crc),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [3:0][15:0] pay;
    logic [2:0]       n;
    logic [15:0]      crcw;
    logic             ok;
    logic [15:0]      calc;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_crc;
  int          m_frames, m_errs, accepted;
  logic [15:0] pay_q[$];
  beat_t       exp_q[$];
  beat_t       act_q[$];
  bit          rand_ready = 0;
  int          bubble = 0;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Remainder of (crc ^ word) * x^16 divided by the full 17-bit generator.
  function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [15:0] w);
    logic [31:0] r;
    r = {crc ^ w, 16'h0000};
    for (int b = 31; b >= 16; b--)
      if (r[b]) r = r ^ ({15'b0, 1'b1, POLY} << (b - 16));
    return r[15:0];
  endfunction

  task automatic model_reset;
    m_crc = INIT; m_frames = 0; m_errs = 0;
    pay_q.delete(); exp_q.delete(); act_q.delete();
  endtask

  task automatic tick(output bit fired);
    bit in_fire, out_fire, done_exp, ok_e;
    logic [15:0] fin_e;
    beat_t b;
    #1;
    in_fire  = bus.in_valid && bus.in_ready;
    out_fire = bus.out_valid && bus.out_ready;
    done_exp = 0; ok_e = 0; fin_e = INIT;
    if (out_fire) begin
      b.d = bus.out_data; b.l = bus.out_last;
      act_q.push_back(b);
    end
    if (in_fire) begin
      accepted++;
      if (!bus.in_last) begin
        pay_q.push_back(bus.in_data);
        m_crc = ref_crc(m_crc, bus.in_data);
      end else begin
        done_exp = 1;
        fin_e    = m_crc;
        ok_e     = (pay_q.size() > 0) && (bus.in_data == m_crc);
        for (int i = 0; i < pay_q.size(); i++) begin
          b.d = pay_q[i]; b.l = (i == pay_q.size() - 1);
          exp_q.push_back(b);
        end
        pay_q.delete();
        m_crc = INIT;
        if (m_frames < 65535) m_frames++;
        if (!ok_e && m_errs < 65535) m_errs++;
      end
    end
    fired = in_fire;
    @(posedge clk);
    @(negedge clk);
    check16("crc_done", {15'b0, crc_done}, {15'b0, done_exp});
    if (done_exp) begin
      check16("crc_ok", {15'b0, crc_ok}, {15'b0, ok_e});
      check16("calc_crc", calc_crc, fin_e);
      check16("frame_cnt", frame_cnt, m_frames[15:0]);
      check16("err_cnt", err_cnt, m_errs[15:0]);
      $display("frame %0d: ok=%0b calc=%h frames=%0d errs=%0d", m_frames, crc_ok, calc_crc, frame_cnt, err_cnt);
    end
  endtask

  task automatic drive_word(input logic [15:0] d, input logic l);
    int budget;
    bit done, f;
    budget = 60; done = 0;
    while (!done && budget > 0) begin
      if (bubble > 0 && $urandom_range(99) < bubble) bus.in_valid = 1'b0;
      else begin
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
      end
      if (rand_ready) bus.out_ready = 1'($urandom_range(1));
      tick(f);
      done = f;
      budget--;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL drive_timeout: word %h not accepted, want accepted", d);
    end
  endtask

  task automatic drain;
    int budget;
    bit f;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    budget = 20;
    while (bus.out_valid && budget > 0) begin
      tick(f);
      budget--;
    end
    if (bus.out_valid) begin
      checks++; errors++;
      $display("FAIL drain_timeout: out_valid=1 want 0");
    end
  endtask

  task automatic compare_model(input string name);
    int n;
    check16({name, "_count"}, 16'(act_q.size()), 16'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s[%0d]: got %h/%0b want %h/%0b", name, i,
                 act_q[i].d, act_q[i].l, exp_q[i].d, exp_q[i].l);
      end
    end
    act_q.delete(); exp_q.delete();
  endtask

  vec_t        vt [6];
  logic [15:0] w4 [4];
  logic [15:0] c;
  int          exp_err;
  bit          f;

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 16'h0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    reset = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    #1;
    check16("rst_out_valid", {15'b0, bus.out_valid}, 16'h0);
    check16("rst_out_last", {15'b0, bus.out_last}, 16'h0);
    check16("rst_out_data", bus.out_data, 16'h0);
    check16("rst_crc_done", {15'b0, crc_done}, 16'h0);
    check16("rst_crc_ok", {15'b0, crc_ok}, 16'h0);
    check16("rst_calc_crc", calc_crc, INIT);
    check16("rst_frame_cnt", frame_cnt, 16'h0);
    check16("rst_err_cnt", err_cnt, 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check16("rst_in_ready", {15'b0, bus.in_ready}, 16'h1);
    @(negedge clk);

    // Fixed frames with known CRCs, out_ready held high.
    for (int i = 0; i < 6; i++) vt[i] = '0;
    vt[0].pay[0] = 16'h0001; vt[0].n = 1; vt[0].crcw = 16'h1021; vt[0].ok = 1; vt[0].calc = 16'h1021;
    vt[1].pay[0] = 16'h0000; vt[1].pay[1] = 16'h0001; vt[1].n = 2;
    vt[1].crcw = 16'h1021; vt[1].ok = 1; vt[1].calc = 16'h1021;
    vt[2].pay[0] = 16'h0001; vt[2].n = 1; vt[2].crcw = 16'h1020; vt[2].ok = 0; vt[2].calc = 16'h1021;
    vt[3].n = 0; vt[3].crcw = 16'h0000; vt[3].ok = 0; vt[3].calc = INIT;
    vt[4].n = 3; vt[4].crcw = 16'h0001; vt[4].ok = 0; vt[4].calc = 16'h0000;
    vt[5].n = 1; vt[5].crcw = 16'h0000; vt[5].ok = 1; vt[5].calc = 16'h0000;
    exp_err = 0;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < int'(vt[i].n); k++) drive_word(vt[i].pay[k], 1'b0);
      drive_word(vt[i].crcw, 1'b1);
      if (!vt[i].ok) exp_err++;
      check16($sformatf("vec%0d_ok", i), {15'b0, crc_ok}, {15'b0, vt[i].ok});
      check16($sformatf("vec%0d_calc", i), calc_crc, vt[i].calc);
      check16($sformatf("vec%0d_frames", i), frame_cnt, 16'(i + 1));
      check16($sformatf("vec%0d_errs", i), err_cnt, 16'(exp_err));
      drain();
      check16($sformatf("vec%0d_nout", i), 16'(act_q.size()), {13'b0, vt[i].n});
      for (int k = 0; k < act_q.size() && k < int'(vt[i].n); k++) begin
        check16($sformatf("vec%0d_out%0d", i, k), act_q[k].d, vt[i].pay[k]);
        check16($sformatf("vec%0d_last%0d", i, k), {15'b0, act_q[k].l},
                {15'b0, (k == int'(vt[i].n) - 1)});
      end
      act_q.delete(); exp_q.delete();
    end

    // Downstream stalled during a 4-word payload.
    w4[0] = 16'hA001; w4[1] = 16'hB002; w4[2] = 16'hC003; w4[3] = 16'hD004;
    bus.out_ready = 1'b0; accepted = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      bus.in_valid = 1'b1; bus.in_last = 1'b0;
      bus.in_data  = w4[(accepted < 4) ? accepted : 3];
      tick(f);
      if (bus.out_valid) check16("stall_out_data", bus.out_data, w4[0]);
    end
    bus.in_valid = 1'b0;
    check16("stall_accepted", 16'(accepted), 16'd2);
    check16("stall_in_ready", {15'b0, bus.in_ready}, 16'h0);
    bus.out_ready = 1'b1;
    drive_word(w4[2], 1'b0);
    drive_word(w4[3], 1'b0);
    c = INIT;
    for (int k = 0; k < 4; k++) c = ref_crc(c, w4[k]);
    drive_word(c, 1'b1);
    check16("stall_ok", {15'b0, crc_ok}, 16'h1);
    drain();
    compare_model("stall_out");

    // Reset in the middle of a frame, then a clean frame.
    drive_word(16'h1111, 1'b0);
    drive_word(16'h2222, 1'b0);
    reset = 1'b0;
    #1;
    check16("midrst_out_valid", {15'b0, bus.out_valid}, 16'h0);
    check16("midrst_calc_crc", calc_crc, INIT);
    check16("midrst_frame_cnt", frame_cnt, 16'h0);
    check16("midrst_err_cnt", err_cnt, 16'h0);
    model_reset();
    @(negedge clk);
    check16("midrst_crc_done", {15'b0, crc_done}, 16'h0);
    reset = 1'b1;
    @(negedge clk);
    drive_word(16'h0001, 1'b0);
    drive_word(16'h1021, 1'b1);
    check16("postrst_ok", {15'b0, crc_ok}, 16'h1);
    check16("postrst_frames", frame_cnt, 16'h1);
    drain();
    compare_model("postrst_out");

    // Random frames, random valid bubbles and downstream backpressure.
    rand_ready = 1; bubble = 25;
    for (int fr = 0; fr < 60; fr++) begin
      int len;
      logic [15:0] w;
      len = $urandom_range(0, 5);
      c = INIT;
      for (int k = 0; k < len; k++) begin
        w = 16'($urandom);
        c = ref_crc(c, w);
        drive_word(w, 1'b0);
      end
      if ($urandom_range(3) == 0) c = c ^ (16'h1 << $urandom_range(15));
      drive_word(c, 1'b1);
    end
    rand_ready = 0; bubble = 0;
    drain();
    compare_model("rand_out");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
